// File: rtl/instruction_fetch.sv
// instruction_fetch: fetches instruction words into a 2-entry {pc, instruction} FIFO.
// It also handles redirects, a sticky halt and decoder backpressure.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted
);
    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

    logic [0:0]  state;
    logic [31:0] fetch_pc;
    logic [1:0]  count;
    logic [31:0] pc0, pc1, ins0, ins1;
    logic        push, pop;

    assign halted      = !rst && state == HALTED;
    assign imem_req    = !rst && state == RUN && !redirect && count < 2'd2;
    assign imem_addr   = fetch_pc;
    assign instr_valid = !rst && state == RUN && count != 2'd0;
    assign instruction = instr_valid ? ins0 : 32'd0;
    assign instr_pc    = instr_valid ? pc0 : 32'd0;
    assign push        = imem_req && imem_ready;
    assign pop         = instr_valid && instr_ready;

    // Entry 0 is always the head; a pop shifts entry 1 down.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            fetch_pc <= RESET_PC & ~32'd3;
            count    <= 2'd0;
        end else if (state == RUN) begin
            if (halt) begin
                state <= HALTED;
                count <= 2'd0;
            end else if (redirect) begin
                count    <= 2'd0;
                fetch_pc <= redirect_pc & ~32'd3;
            end else begin
                if (push)
                    fetch_pc <= fetch_pc + 32'd4;
                if (push && pop) begin
                    pc0  <= fetch_pc;
                    ins0 <= imem_rdata;
                end else if (pop) begin
                    pc0   <= pc1;
                    ins0  <= ins1;
                    count <= count - 2'd1;
                end else if (push) begin
                    if (count == 2'd0) begin
                        pc0  <= fetch_pc;
                        ins0 <= imem_rdata;
                    end else begin
                        pc1  <= fetch_pc;
                        ins1 <= imem_rdata;
                    end
                    count <= count + 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table-driven directed vectors plus hand-written halt/reset sequences.
// Memory returns word(addr) so every expected instruction is derived from its pc.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        rst, imem_ready, instr_ready, redirect, halt;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, instr_valid, halted;
    logic [31:0] imem_addr, instruction, instr_pc;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst, rdy, ir, rd;
        logic [31:0] rpc;
        logic        hl;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] ipc;
        logic        hd;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = word(imem_addr);

    instruction_fetch dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instruction(instruction), .instr_pc(instr_pc),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .halted(halted)
    );

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic rdy, input logic ir, input logic rd,
                       input logic [31:0] rpc, input logic hl, input logic req,
                       input logic [31:0] addr, input logic v, input logic [31:0] ipc,
                       input logic hd);
        vec_t t;
        t.rst = r; t.rdy = rdy; t.ir = ir; t.rd = rd; t.rpc = rpc; t.hl = hl;
        t.req = req; t.addr = addr; t.v = v; t.ipc = ipc; t.hd = hd;
        vecs.push_back(t);
    endtask

    task automatic check_outs(input int i, input logic req, input logic [31:0] addr,
                              input logic v, input logic [31:0] ipc, input logic hd);
        chk("imem_req", i, {31'd0, imem_req}, {31'd0, req});
        chk("imem_addr", i, imem_addr, addr);
        chk("instr_valid", i, {31'd0, instr_valid}, {31'd0, v});
        chk("instr_pc", i, instr_pc, v ? ipc : 32'd0);
        chk("instruction", i, instruction, v ? word(ipc) : 32'd0);
        chk("halted", i, {31'd0, halted}, {31'd0, hd});
    endtask

    initial begin
        bit seen;
        // rst rdy ir rd rpc hl | req addr v ipc hd
        add(1,1,1,0,0,0, 0,32'h0,0,32'h0,0);
        add(0,1,1,0,0,0, 1,32'h0,0,32'h0,0);
        add(0,1,1,0,0,0, 1,32'h4,1,32'h0,0);
        add(0,1,1,0,0,0, 1,32'h8,1,32'h4,0);
        add(0,1,1,0,0,0, 1,32'hC,1,32'h8,0);
        add(0,1,1,0,0,0, 1,32'h10,1,32'hC,0);
        add(1,1,1,0,0,0, 0,32'h14,0,32'h0,0);
        add(0,1,0,0,0,0, 1,32'h0,0,32'h0,0);
        add(0,1,0,0,0,0, 1,32'h4,1,32'h0,0);
        add(0,1,0,0,0,0, 0,32'h8,1,32'h0,0);
        add(0,1,0,0,0,0, 0,32'h8,1,32'h0,0);
        add(0,1,0,0,0,0, 0,32'h8,1,32'h0,0);
        add(0,1,1,0,0,0, 0,32'h8,1,32'h0,0);
        add(0,1,1,0,0,0, 1,32'h8,1,32'h4,0);
        add(0,1,0,0,0,0, 1,32'hC,1,32'h8,0);
        add(0,1,1,1,32'h0000_0103,0, 0,32'h10,1,32'h8,0);
        add(0,1,1,0,0,0, 1,32'h100,0,32'h0,0);
        add(0,1,1,0,0,0, 1,32'h104,1,32'h100,0);
        add(0,1,1,1,32'h200,1, 0,32'h108,1,32'h104,0);
        add(0,1,1,0,0,0, 0,32'h108,0,32'h0,1);
        add(0,1,1,1,32'h300,0, 0,32'h108,0,32'h0,1);
        add(0,1,1,0,0,0, 0,32'h108,0,32'h0,1);
        add(1,1,1,0,0,0, 0,32'h108,0,32'h0,0);
        add(0,1,1,0,0,0, 1,32'h0,0,32'h0,0);
        add(0,1,1,0,0,0, 1,32'h4,1,32'h0,0);
        add(0,1,1,1,32'hFFFF_FFF8,0, 0,32'h8,1,32'h4,0);
        add(0,0,1,0,0,0, 1,32'hFFFF_FFF8,0,32'h0,0);
        add(0,1,1,0,0,0, 1,32'hFFFF_FFF8,0,32'h0,0);
        add(0,0,1,0,0,0, 1,32'hFFFF_FFFC,1,32'hFFFF_FFF8,0);
        add(0,0,1,0,0,0, 1,32'hFFFF_FFFC,0,32'h0,0);
        add(0,1,1,0,0,0, 1,32'hFFFF_FFFC,0,32'h0,0);
        add(0,1,1,0,0,0, 1,32'h0,1,32'hFFFF_FFFC,0);
        add(0,0,1,0,0,0, 1,32'h4,1,32'h0,0);
        add(0,1,0,0,0,0, 1,32'h4,0,32'h0,0);
        add(0,1,0,0,0,0, 1,32'h8,1,32'h4,0);
        add(0,1,0,0,0,0, 0,32'hC,1,32'h4,0);
        add(1,1,1,0,0,0, 0,32'hC,0,32'h0,0);
        add(0,0,1,0,0,0, 1,32'h0,0,32'h0,0);

        rst = 1; imem_ready = 0; instr_ready = 0; redirect = 0; redirect_pc = 0; halt = 0;
        @(posedge clk);
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; imem_ready = vecs[i].rdy; instr_ready = vecs[i].ir;
            redirect = vecs[i].rd; redirect_pc = vecs[i].rpc; halt = vecs[i].hl;
            #1;
            check_outs(i, vecs[i].req, vecs[i].addr, vecs[i].v, vecs[i].ipc, vecs[i].hd);
        end

        // Halt alone during streaming, then stays halted for many cycles.
        @(negedge clk);
        imem_ready = 1; instr_ready = 1; rst = 0; redirect = 0; halt = 0;
        repeat (3) @(negedge clk);
        halt = 1;
        @(negedge clk);
        halt = 0;
        for (int k = 0; k < 8; k++) begin
            redirect = k[0]; redirect_pc = 32'h40;
            #1;
            chk("halt_req", k, {31'd0, imem_req}, 32'd0);
            chk("halt_valid", k, {31'd0, instr_valid}, 32'd0);
            chk("halt_flag", k, {31'd0, halted}, 32'd1);
            @(negedge clk);
        end
        redirect = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        chk("resume_addr", 0, imem_addr, 32'h0);
        chk("resume_req", 0, {31'd0, imem_req}, 32'd1);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            #1;
            seen = instr_valid;
        end
        chk("resume_seen", 0, {31'd0, seen}, 32'd1);
        if (seen) begin
            chk("resume_pc", 0, instr_pc, 32'h0);
            chk("resume_ins", 0, instruction, word(32'h0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
